// File: rtl/kbd_pkg.sv
// Shared PS/2 keyboard definitions: scan-code prefixes,
// default key codes, direction encoding and decoder FSM states.
package kbd_pkg;

   localparam logic [7:0] SC_EXT = 8'hE0;
   localparam logic [7:0] SC_BRK = 8'hF0;

   localparam logic [7:0] KEY_LEFT_DEF  = 8'h6B;
   localparam logic [7:0] KEY_RIGHT_DEF = 8'h74;
   localparam logic [7:0] KEY_SHOOT_DEF = 8'h29;

   localparam logic DIR_LEFT  = 1'b0;
   localparam logic DIR_RIGHT = 1'b1;

   typedef enum logic [1:0] {
      IDLE,
      EXT,
      BRK,
      EXT_BRK
   } kbdState_t;

endpackage

// File: rtl/key_press_decoder.sv
// PS/2 scan-code decoder producing player move levels and a
// per-frame shoot pulse.
// Ports: clk, resetN (async, active-low), din/dinNew (scan byte
// and strobe), startOfFrame (frame pulse), leftPress/rightPress
// (move levels), shootPress (one-cycle shoot request).
module key_press_decoder
   import kbd_pkg::*;
#(
   parameter logic [7:0]  KEY_LEFT       = KEY_LEFT_DEF,
   parameter logic [7:0]  KEY_RIGHT      = KEY_RIGHT_DEF,
   parameter logic [7:0]  KEY_SHOOT      = KEY_SHOOT_DEF,
   parameter int unsigned PREFIX_TIMEOUT = 50000
) (
   input  logic       clk,
   input  logic       resetN,
   input  logic [7:0] din,
   input  logic       dinNew,
   input  logic       startOfFrame,
   output logic       leftPress,
   output logic       rightPress,
   output logic       shootPress
);

   localparam int TW = $clog2(PREFIX_TIMEOUT + 1);
   localparam logic [TW-1:0] TMO_LAST = TW'(PREFIX_TIMEOUT - 1);

   kbdState_t     state, nextState;
   logic [TW-1:0] tmoCnt, tmoCntNext;

   logic leftHeld, rightHeld, shootHeld;
   logic shootPending, lastDir;

   logic seqDone, seqExt, seqBrk;
   logic hitLeft, hitRight, hitShoot;
   logic shootNew, sofFire;

   always_comb begin
      nextState  = state;
      tmoCntNext = '0;
      seqDone    = 1'b0;
      seqExt     = 1'b0;
      seqBrk     = 1'b0;
      if (dinNew) begin
         unique case (state)
            IDLE: begin
               if (din == SC_EXT)
                  nextState = EXT;
               else if (din == SC_BRK)
                  nextState = BRK;
               else
                  seqDone = 1'b1;
            end
            EXT: begin
               if (din == SC_BRK)
                  nextState = EXT_BRK;
               else if (din != SC_EXT) begin
                  nextState = IDLE;
                  seqDone   = 1'b1;
                  seqExt    = 1'b1;
               end
            end
            BRK: begin
               if (din == SC_EXT)
                  nextState = EXT;
               else begin
                  nextState = IDLE;
                  seqDone   = 1'b1;
                  seqBrk    = 1'b1;
               end
            end
            EXT_BRK: begin
               nextState = IDLE;
               seqDone   = 1'b1;
               seqExt    = 1'b1;
               seqBrk    = 1'b1;
            end
         endcase
      end else if (state != IDLE) begin
         // The edge on which the count would reach the limit
         // abandons the partial sequence.
         if (tmoCnt == TMO_LAST)
            nextState = IDLE;
         else
            tmoCntNext = tmoCnt + 1'b1;
      end
   end

   assign hitLeft  = seqDone & seqExt & (din == KEY_LEFT);
   assign hitRight = seqDone & seqExt & (din == KEY_RIGHT);
   assign hitShoot = seqDone & ~seqExt & (din == KEY_SHOOT);
   assign shootNew = hitShoot & ~seqBrk & ~shootHeld;
   assign sofFire  = startOfFrame & shootPending;

   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         state        <= IDLE;
         tmoCnt       <= '0;
         leftHeld     <= 1'b0;
         rightHeld    <= 1'b0;
         shootHeld    <= 1'b0;
         shootPending <= 1'b0;
         lastDir      <= DIR_LEFT;
         shootPress   <= 1'b0;
      end else begin
         state  <= nextState;
         tmoCnt <= tmoCntNext;
         if (hitLeft) begin
            leftHeld <= ~seqBrk;
            if (!seqBrk)
               lastDir <= DIR_LEFT;
         end
         if (hitRight) begin
            rightHeld <= ~seqBrk;
            if (!seqBrk)
               lastDir <= DIR_RIGHT;
         end
         if (hitShoot)
            shootHeld <= ~seqBrk;
         // A make landing on the frame edge is kept for the
         // next frame rather than merged into this one.
         shootPending <= (shootPending & ~sofFire) | shootNew;
         shootPress   <= sofFire;
      end
   end

   assign leftPress  = leftHeld &
                       (~rightHeld | (lastDir == DIR_LEFT));
   assign rightPress = rightHeld &
                       (~leftHeld | (lastDir == DIR_RIGHT));

endmodule

// File: tb/tb_key_press_decoder.sv
// Self-checking bench for key_press_decoder: directed vector
// table, timeout/reset sequences and randomized model checks.
module tb_key_press_decoder;

   localparam int PT = 8;

   logic       clk = 1'b0;
   logic       resetN;
   logic [7:0] din;
   logic       dinNew;
   logic       startOfFrame;
   logic       leftPress, rightPress, shootPress;

   int nChk  = 0;
   int nFail = 0;

   key_press_decoder #(
      .PREFIX_TIMEOUT(PT)
   ) dut (
      .clk         (clk),
      .resetN      (resetN),
      .din         (din),
      .dinNew      (dinNew),
      .startOfFrame(startOfFrame),
      .leftPress   (leftPress),
      .rightPress  (rightPress),
      .shootPress  (shootPress)
   );

   always #5 clk = ~clk;

   // Reference model: sequence prefix flags plus key status
   bit mExt, mBrk;
   bit mL, mR, mS, mLastR, mPend, mShot;
   int edgeIdx, mLastIdx;

   function automatic void modelReset();
      mExt = 0; mBrk = 0;
      mL = 0; mR = 0; mS = 0;
      mLastR = 0; mPend = 0; mShot = 0;
      mLastIdx = 0;
   endfunction

   function automatic void keyEvent(logic [7:0] b,
                                    bit ext, bit brk);
      if (ext && b == 8'h6B) begin
         mL = !brk;
         if (!brk) mLastR = 0;
      end
      if (ext && b == 8'h74) begin
         mR = !brk;
         if (!brk) mLastR = 1;
      end
      if (!ext && b == 8'h29) begin
         if (brk) mS = 0;
         else if (!mS) begin
            mS = 1;
            mPend = 1;
         end
      end
   endfunction

   function automatic void modelEdge(logic [7:0] b,
                                     bit n, bit s);
      bit ext, brk;
      mShot = s && mPend;
      if (mShot) mPend = 0;
      if (n) begin
         if ((mExt || mBrk) &&
             (edgeIdx - mLastIdx - 1 >= PT)) begin
            mExt = 0;
            mBrk = 0;
         end
         mLastIdx = edgeIdx;
         if (mExt && mBrk) begin
            mExt = 0; mBrk = 0;
            keyEvent(b, 1, 1);
         end else if (b == 8'hE0) begin
            mExt = 1; mBrk = 0;
         end else if (b == 8'hF0 && !mBrk) begin
            mBrk = 1;
         end else begin
            ext = mExt; brk = mBrk;
            mExt = 0; mBrk = 0;
            keyEvent(b, ext, brk);
         end
      end
      edgeIdx++;
   endfunction

   function automatic bit expL();
      return mL && (!mR || !mLastR);
   endfunction

   function automatic bit expR();
      return mR && (!mL || mLastR);
   endfunction

   task automatic chk(input string nm,
                      input logic act, input logic exp);
      nChk++;
      if (act !== exp) begin
         nFail++;
         $display("FAIL %s: got %0b expected %0b",
                  nm, act, exp);
      end
   endtask

   task automatic step(input logic [7:0] b,
                       input logic n, input logic s);
      din = b;
      dinNew = n;
      startOfFrame = s;
      @(posedge clk);
      modelEdge(b, n, s);
      #1;
      din = 8'h00;
      dinNew = 1'b0;
      startOfFrame = 1'b0;
   endtask

   task automatic byteIn(input logic [7:0] b);
      step(b, 1'b1, 1'b0);
   endtask

   task automatic idle(input int k);
      for (int i = 0; i < k; i++)
         step(8'h00, 1'b0, 1'b0);
   endtask

   typedef struct {
      logic [7:0] b;
      logic       n;
      logic       s;
      logic       eL;
      logic       eR;
      logic       eS;
   } vec_t;

   vec_t vecs[$];

   function automatic void add(logic [7:0] b, logic n,
                               logic s, logic eL,
                               logic eR, logic eS);
      vec_t v;
      v.b = b; v.n = n; v.s = s;
      v.eL = eL; v.eR = eR; v.eS = eS;
      vecs.push_back(v);
   endfunction

   logic [7:0] codes [7];

   initial begin
      codes[0] = 8'hE0; codes[1] = 8'hF0;
      codes[2] = 8'h6B; codes[3] = 8'h74;
      codes[4] = 8'h29; codes[5] = 8'h1C;
      codes[6] = 8'h6B;

      // left make then break
      add(8'hE0, 1, 0, 0, 0, 0);
      add(8'h6B, 1, 0, 1, 0, 0);
      add(8'hE0, 1, 0, 1, 0, 0);
      add(8'hF0, 1, 0, 1, 0, 0);
      add(8'h6B, 1, 0, 0, 0, 0);
      // left, then right overrides, right released
      add(8'hE0, 1, 0, 0, 0, 0);
      add(8'h6B, 1, 0, 1, 0, 0);
      add(8'hE0, 1, 0, 1, 0, 0);
      add(8'h74, 1, 0, 0, 1, 0);
      add(8'hE0, 1, 0, 0, 1, 0);
      add(8'hF0, 1, 0, 0, 1, 0);
      add(8'h74, 1, 0, 1, 0, 0);
      add(8'hE0, 1, 0, 1, 0, 0);
      add(8'hF0, 1, 0, 1, 0, 0);
      add(8'h6B, 1, 0, 0, 0, 0);
      // shoot auto-repeat collapses to one pulse
      for (int i = 0; i < 5; i++)
         add(8'h29, 1, 0, 0, 0, 0);
      add(8'hF0, 1, 0, 0, 0, 0);
      add(8'h29, 1, 0, 0, 0, 0);
      add(8'h00, 0, 1, 0, 0, 1);
      add(8'h00, 0, 0, 0, 0, 0);
      add(8'h00, 0, 1, 0, 0, 0);
      add(8'h00, 0, 0, 0, 0, 0);
      // shoot make on the frame edge waits a frame
      add(8'h29, 1, 1, 0, 0, 0);
      add(8'h00, 0, 0, 0, 0, 0);
      add(8'h00, 0, 1, 0, 0, 1);
      add(8'h00, 0, 0, 0, 0, 0);
      add(8'hF0, 1, 0, 0, 0, 0);
      add(8'h29, 1, 0, 0, 0, 0);
      // non-extended 6B is not the left key
      add(8'h6B, 1, 0, 0, 0, 0);

      resetN = 1'b0;
      din = 8'h00;
      dinNew = 1'b0;
      startOfFrame = 1'b0;
      edgeIdx = 0;
      modelReset();
      repeat (2) @(posedge clk);
      #3;
      chk("reset_left", leftPress, 1'b0);
      chk("reset_right", rightPress, 1'b0);
      chk("reset_shoot", shootPress, 1'b0);
      resetN = 1'b1;
      @(posedge clk);
      #1;

      foreach (vecs[i]) begin
         step(vecs[i].b, vecs[i].n, vecs[i].s);
         chk($sformatf("vec%0d_left", i),
             leftPress, vecs[i].eL);
         chk($sformatf("vec%0d_right", i),
             rightPress, vecs[i].eR);
         chk($sformatf("vec%0d_shoot", i),
             shootPress, vecs[i].eS);
      end

      // prefix timeout: 8 idle cycles abandons E0
      byteIn(8'hE0);
      idle(PT);
      byteIn(8'h6B);
      chk("tmo_expired_left", leftPress, 1'b0);
      // 7 idle cycles still completes the sequence
      byteIn(8'hE0);
      idle(PT - 1);
      byteIn(8'h6B);
      chk("tmo_live_left", leftPress, 1'b1);
      // timeout also applies to a pending break
      byteIn(8'hE0);
      byteIn(8'hF0);
      idle(PT);
      byteIn(8'h6B);
      chk("tmo_brk_left", leftPress, 1'b1);
      byteIn(8'hE0);
      byteIn(8'hF0);
      byteIn(8'h6B);
      chk("tmo_release_left", leftPress, 1'b0);

      // async reset mid-sequence with left held, shoot pending
      byteIn(8'hE0);
      byteIn(8'h6B);
      byteIn(8'h29);
      byteIn(8'hE0);
      byteIn(8'hF0);
      chk("pre_rst_left", leftPress, 1'b1);
      #2;
      resetN = 1'b0;
      #1;
      modelReset();
      chk("rst_left", leftPress, 1'b0);
      chk("rst_right", rightPress, 1'b0);
      chk("rst_shoot", shootPress, 1'b0);
      #4;
      resetN = 1'b1;
      byteIn(8'h6B);
      chk("post_rst_left", leftPress, 1'b0);
      step(8'h00, 1'b0, 1'b1);
      chk("post_rst_shoot", shootPress, 1'b0);

      // randomized traffic against the reference model
      for (int t = 0; t < 1500; t++) begin
         int gap;
         gap = ($urandom_range(0, 15) == 0) ?
               int'($urandom_range(6, 10)) :
               int'($urandom_range(0, 2));
         for (int g = 0; g <= gap; g++) begin
            logic sof;
            logic nb;
            sof = ($urandom_range(0, 7) == 0);
            nb  = (g == gap);
            step(nb ? codes[$urandom_range(0, 6)] : 8'h00,
                 nb, sof);
            chk("rnd_left", leftPress, expL());
            chk("rnd_right", rightPress, expR());
            chk("rnd_shoot", shootPress, mShot);
            chk("rnd_excl", leftPress & rightPress, 1'b0);
         end
      end

      $display("End of test - %0d assertions evaluated, %0d failures",
               nChk, nFail);
      $finish;
   end

endmodule
